vram_arbiter: RTL

- Responder side of the video-memory fetch interface driven by the 1 bpp/2 bpp VGA generator.
- Owns the single-ported synchronous video RAM. It serves one-cycle `req` fetch strobes from the VGA generator at fixed latency. It interleaves CPU (#8000-#9FFF) read/write accesses into the remaining memory slots.
- Sits between the VGA generator, the CPU bus decode and the video RAM macro.

---
 rtl/vram_arbiter.sv | 114 +++++++++++
 1 files changed

// File: rtl/vram_arbiter.sv
// Single-ported video RAM arbiter: fixed-latency VGA fetches take priority,
// CPU read/write accesses fill the remaining memory slots.
module vram_arbiter #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_address,
  output logic [DATA_W-1:0] vga_data,
  input  logic              cpu_cs,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic [DATA_W-1:0] cpu_din,
  output logic [DATA_W-1:0] cpu_dout,
  output logic              cpu_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    OWN_NONE   = 2'd0,
    OWN_VID    = 2'd1,
    OWN_CPU_RD = 2'd2,
    OWN_CPU_WR = 2'd3
  } owner_t;

  // slot_own: owner of the address currently on mem_addr.
  // cap_own:  owner of the data currently on mem_rdata.
  owner_t slot_own;
  owner_t cap_own;

  logic              pending;
  logic              need_low;
  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_din;

  logic              cpu_busy;
  logic              new_req;
  logic              cpu_avail;
  logic              cur_we;
  logic [ADDR_W-1:0] cur_addr;
  logic [DATA_W-1:0] cur_din;

  // A fresh request bypasses the latch so an idle slot is used immediately.
  always_comb begin
    cpu_busy  = pending || (slot_own == OWN_CPU_RD) || (slot_own == OWN_CPU_WR) ||
                (cap_own == OWN_CPU_RD);
    new_req   = cpu_cs && !cpu_busy && !cpu_ready && !need_low;
    cpu_avail = pending || new_req;
    cur_we    = pending ? lat_we   : cpu_we;
    cur_addr  = pending ? lat_addr : cpu_address;
    cur_din   = pending ? lat_din  : cpu_din;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slot_own  <= OWN_NONE;
      cap_own   <= OWN_NONE;
      pending   <= 1'b0;
      need_low  <= 1'b0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_din   <= '0;
      vga_data  <= '0;
      cpu_dout  <= '0;
      cpu_ready <= 1'b0;
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
    end else begin
      // One access per cs assertion: re-arm only after cs is seen low.
      if (!cpu_cs)
        need_low <= 1'b0;
      else if (new_req)
        need_low <= 1'b1;

      if (new_req) begin
        lat_we   <= cpu_we;
        lat_addr <= cpu_address;
        lat_din  <= cpu_din;
      end

      if (vga_req) begin
        slot_own <= OWN_VID;
        mem_addr <= vga_address;
        mem_we   <= 1'b0;
        if (new_req)
          pending <= 1'b1;
      end else if (cpu_avail) begin
        slot_own  <= cur_we ? OWN_CPU_WR : OWN_CPU_RD;
        mem_addr  <= cur_addr;
        mem_we    <= cur_we;
        mem_wdata <= cur_din;
        pending   <= 1'b0;
      end else begin
        slot_own <= OWN_NONE;
        mem_we   <= 1'b0;
      end

      cap_own <= slot_own;
      if (cap_own == OWN_VID)
        vga_data <= mem_rdata;
      if (cap_own == OWN_CPU_RD)
        cpu_dout <= mem_rdata;
      cpu_ready <= (slot_own == OWN_CPU_WR) || (cap_own == OWN_CPU_RD);
    end
  end

endmodule
